// File: rtl/wb_pipe_pkg.sv
// Shared definitions for the write-back pipeline chain: WB control bit indices,
// the default-width entry record and the legal DEPTH range.
package wb_pipe_pkg;

   localparam int CTRL_WB_REGWRITE = 0;
   localparam int CTRL_WB_MEMTOREG = 1;

   localparam int WB_DEPTH_MIN = 1;
   localparam int WB_DEPTH_MAX = 8;

   typedef struct packed {
      logic [1:0]  ctrl;
      logic [31:0] read_data;
      logic [31:0] alu_result;
      logic [4:0]  write_reg;
   } wb_entry_t;

endpackage

// File: rtl/wb_pipe_stage.sv
// One stage of the write-back chain: valid bit plus payload with flush > stall > load.
// Define WB_PIPE_FLUSH_CLR_EN to make flush zero the payload as well as the valid bit.
module wb_pipe_stage
   import wb_pipe_pkg::*;
#(
   parameter int CTRL_W = 2,
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              valid_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] read_data_i,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic [REG_W-1:0]  write_reg_i,
   output logic              valid_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] read_data_o,
   output logic [DATA_W-1:0] alu_result_o,
   output logic [REG_W-1:0]  write_reg_o
);

   logic              valid_q, valid_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [DATA_W-1:0] read_data_q, read_data_d;
   logic [DATA_W-1:0] alu_result_q, alu_result_d;
   logic [REG_W-1:0]  write_reg_q, write_reg_d;

   always_comb begin
      valid_d      = valid_q;
      ctrl_d       = ctrl_q;
      read_data_d  = read_data_q;
      alu_result_d = alu_result_q;
      write_reg_d  = write_reg_q;
      if (flush_i) begin
         valid_d = 1'b0;
`ifdef WB_PIPE_FLUSH_CLR_EN
         ctrl_d       = '0;
         read_data_d  = '0;
         alu_result_d = '0;
         write_reg_d  = '0;
`endif
      end else if (!stall_i) begin
         // payload follows the slot even for bubbles; only valid marks it as real
         valid_d      = valid_i;
         ctrl_d       = ctrl_i;
         read_data_d  = read_data_i;
         alu_result_d = alu_result_i;
         write_reg_d  = write_reg_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         ctrl_q       <= '0;
         read_data_q  <= '0;
         alu_result_q <= '0;
         write_reg_q  <= '0;
      end else begin
         valid_q      <= valid_d;
         ctrl_q       <= ctrl_d;
         read_data_q  <= read_data_d;
         alu_result_q <= alu_result_d;
         write_reg_q  <= write_reg_d;
      end
   end

   assign valid_o      = valid_q;
   assign ctrl_o       = ctrl_q;
   assign read_data_o  = read_data_q;
   assign alu_result_o = alu_result_q;
   assign write_reg_o  = write_reg_q;

endmodule

// File: rtl/wb_pipe_chain.sv
// DEPTH-stage MEM/WB register chain with valid, stall, flush, resolved write-back and
// per-stage forwarding taps. Optional macro: WB_PIPE_FLUSH_CLR_EN (flush also clears payload).
module wb_pipe_chain
   import wb_pipe_pkg::*;
#(
   parameter int CTRL_W = 2,
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int DEPTH  = 1,
   localparam int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   stall_i,
   input  logic                   flush_i,
   input  logic                   in_valid,
   input  logic [CTRL_W-1:0]      ctrl_wb_in,
   input  logic [DATA_W-1:0]      read_data_in,
   input  logic [DATA_W-1:0]      alu_result_in,
   input  logic [REG_W-1:0]       write_reg_in,
   output logic                   out_valid,
   output logic [CTRL_W-1:0]      mem_ctrl_wb,
   output logic [DATA_W-1:0]      read_data,
   output logic [DATA_W-1:0]      mem_alu_result,
   output logic [REG_W-1:0]       mem_write_reg,
   output logic                   wb_en,
   output logic [DATA_W-1:0]      wb_data,
   output logic [DEPTH-1:0]       fwd_we,
   output logic [DEPTH*REG_W-1:0] fwd_reg,
   output logic [OCC_W-1:0]       occ
);

   if (DEPTH < WB_DEPTH_MIN || DEPTH > WB_DEPTH_MAX) begin : g_bad_depth
      $error("wb_pipe_chain: DEPTH out of range");
   end

   logic              valid_s [DEPTH];
   logic [CTRL_W-1:0] ctrl_s  [DEPTH];
   logic [DATA_W-1:0] rdata_s [DEPTH];
   logic [DATA_W-1:0] alu_s   [DEPTH];
   logic [REG_W-1:0]  wreg_s  [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic              vld_in;
      logic [CTRL_W-1:0] ctrl_in;
      logic [DATA_W-1:0] rdata_in;
      logic [DATA_W-1:0] alu_in;
      logic [REG_W-1:0]  wreg_in;

      if (k == 0) begin : g_head
         assign vld_in   = in_valid;
         assign ctrl_in  = ctrl_wb_in;
         assign rdata_in = read_data_in;
         assign alu_in   = alu_result_in;
         assign wreg_in  = write_reg_in;
      end else begin : g_link
         assign vld_in   = valid_s[k-1];
         assign ctrl_in  = ctrl_s[k-1];
         assign rdata_in = rdata_s[k-1];
         assign alu_in   = alu_s[k-1];
         assign wreg_in  = wreg_s[k-1];
      end

      wb_pipe_stage #(
         .CTRL_W (CTRL_W),
         .DATA_W (DATA_W),
         .REG_W  (REG_W)
      ) u_stage (
         .clk          (clk),
         .rst_n        (rst_n),
         .stall_i      (stall_i),
         .flush_i      (flush_i),
         .valid_i      (vld_in),
         .ctrl_i       (ctrl_in),
         .read_data_i  (rdata_in),
         .alu_result_i (alu_in),
         .write_reg_i  (wreg_in),
         .valid_o      (valid_s[k]),
         .ctrl_o       (ctrl_s[k]),
         .read_data_o  (rdata_s[k]),
         .alu_result_o (alu_s[k]),
         .write_reg_o  (wreg_s[k])
      );

      assign fwd_we[k]                  = valid_s[k] & ctrl_s[k][CTRL_WB_REGWRITE];
      assign fwd_reg[k*REG_W +: REG_W]  = wreg_s[k];
   end

   // occupancy tracks the valid bits' next state so it stays a pure register output
   logic [OCC_W-1:0] occ_q, occ_d;
   int               occ_cnt;

   always_comb begin
      occ_cnt = in_valid ? 1 : 0;
      for (int k = 0; k < DEPTH - 1; k++) begin
         occ_cnt = occ_cnt + (valid_s[k] ? 1 : 0);
      end
      occ_d = occ_q;
      if (flush_i) begin
         occ_d = '0;
      end else if (!stall_i) begin
         occ_d = OCC_W'(occ_cnt);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occ            = occ_q;
   assign out_valid      = valid_s[DEPTH-1];
   assign mem_ctrl_wb    = ctrl_s[DEPTH-1];
   assign read_data      = rdata_s[DEPTH-1];
   assign mem_alu_result = alu_s[DEPTH-1];
   assign mem_write_reg  = wreg_s[DEPTH-1];

   // register 0 is hard-wired, so writes to it are dropped here
   assign wb_en   = out_valid & mem_ctrl_wb[CTRL_WB_REGWRITE] & (mem_write_reg != '0);
   assign wb_data = mem_ctrl_wb[CTRL_WB_MEMTOREG] ? read_data : mem_alu_result;

endmodule

// File: tb/tb_wb_pipe_chain.sv
// Bench for wb_pipe_chain: DEPTH=1,2,3 instances on shared inputs, a table for DEPTH=1,
// hand sequences for stall/flush/forward/reset, and random traffic against a reference model.
module tb_wb_pipe_chain;
   import wb_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_i, flush_i, in_valid;
   logic [1:0]  ctrl_in;
   logic [31:0] rd_in, alu_in;
   logic [4:0]  wr_in;

   logic        ov1, ov2, ov3, en1, en2, en3;
   logic [1:0]  c1, c2, c3;
   logic [31:0] rd1, rd2, rd3, alu1, alu2, alu3, wd1, wd2, wd3;
   logic [4:0]  wr1, wr2, wr3;
   logic [0:0]  fwe1;
   logic [1:0]  fwe2;
   logic [2:0]  fwe3;
   logic [4:0]  freg1;
   logic [9:0]  freg2;
   logic [14:0] freg3;
   logic [0:0]  occ1;
   logic [1:0]  occ2, occ3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_pipe_chain #(.DEPTH(1)) u1 (
      .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i), .in_valid(in_valid),
      .ctrl_wb_in(ctrl_in), .read_data_in(rd_in), .alu_result_in(alu_in), .write_reg_in(wr_in),
      .out_valid(ov1), .mem_ctrl_wb(c1), .read_data(rd1), .mem_alu_result(alu1),
      .mem_write_reg(wr1), .wb_en(en1), .wb_data(wd1), .fwd_we(fwe1), .fwd_reg(freg1), .occ(occ1));

   wb_pipe_chain #(.DEPTH(2)) u2 (
      .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i), .in_valid(in_valid),
      .ctrl_wb_in(ctrl_in), .read_data_in(rd_in), .alu_result_in(alu_in), .write_reg_in(wr_in),
      .out_valid(ov2), .mem_ctrl_wb(c2), .read_data(rd2), .mem_alu_result(alu2),
      .mem_write_reg(wr2), .wb_en(en2), .wb_data(wd2), .fwd_we(fwe2), .fwd_reg(freg2), .occ(occ2));

   wb_pipe_chain #(.DEPTH(3)) u3 (
      .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i), .in_valid(in_valid),
      .ctrl_wb_in(ctrl_in), .read_data_in(rd_in), .alu_result_in(alu_in), .write_reg_in(wr_in),
      .out_valid(ov3), .mem_ctrl_wb(c3), .read_data(rd3), .mem_alu_result(alu3),
      .mem_write_reg(wr3), .wb_en(en3), .wb_data(wd3), .fwd_we(fwe3), .fwd_reg(freg3), .occ(occ3));

   // reference: one slot list per depth, slot 0 nearest the input
   wb_entry_t me [1:3][0:7];
   logic      mv [1:3][0:7];

`ifdef WB_PIPE_FLUSH_CLR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 1; d <= 3; d++)
         for (int k = 0; k < 8; k++) begin
            mv[d][k] = 1'b0;
            me[d][k] = '0;
         end
   endtask

   task automatic model_step();
      for (int d = 1; d <= 3; d++) begin
         if (flush_i) begin
            for (int k = 0; k < d; k++) begin
               mv[d][k] = 1'b0;
               if (CLR) me[d][k] = '0;
            end
         end else if (!stall_i) begin
            for (int k = d - 1; k > 0; k--) begin
               mv[d][k] = mv[d][k-1];
               me[d][k] = me[d][k-1];
            end
            mv[d][0] = in_valid;
            me[d][0] = '{ctrl: ctrl_in, read_data: rd_in, alu_result: alu_in, write_reg: wr_in};
         end
      end
   endtask

   task automatic check_dut(input int d, input logic ov, input logic [1:0] c,
                            input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] wr,
                            input logic en, input logic [31:0] wd, input logic [2:0] fwe,
                            input logic [14:0] freg, input logic [1:0] occ);
      wb_entry_t   last;
      logic        lv;
      logic [2:0]  e_fwe;
      logic [14:0] e_freg;
      int          cnt;
      last   = me[d][d-1];
      lv     = mv[d][d-1];
      e_fwe  = '0;
      e_freg = '0;
      cnt    = 0;
      for (int k = 0; k < d; k++) begin
         e_fwe[k]        = mv[d][k] & me[d][k].ctrl[0];
         e_freg[k*5 +: 5] = me[d][k].write_reg;
         if (mv[d][k]) cnt++;
      end
      cmp($sformatf("d%0d_out_valid", d), 32'(ov), 32'(lv));
      cmp($sformatf("d%0d_ctrl", d), 32'(c), 32'(last.ctrl));
      cmp($sformatf("d%0d_read_data", d), rd, last.read_data);
      cmp($sformatf("d%0d_alu", d), alu, last.alu_result);
      cmp($sformatf("d%0d_write_reg", d), 32'(wr), 32'(last.write_reg));
      cmp($sformatf("d%0d_wb_en", d), 32'(en),
          32'(lv && last.ctrl[0] && last.write_reg != 5'd0));
      cmp($sformatf("d%0d_wb_data", d), wd, last.ctrl[1] ? last.read_data : last.alu_result);
      cmp($sformatf("d%0d_fwd_we", d), 32'(fwe), 32'(e_fwe));
      cmp($sformatf("d%0d_fwd_reg", d), 32'(freg), 32'(e_freg));
      cmp($sformatf("d%0d_occ", d), 32'(occ), cnt);
   endtask

   task automatic check_all();
      check_dut(1, ov1, c1, rd1, alu1, wr1, en1, wd1, {2'b0, fwe1}, {10'b0, freg1}, {1'b0, occ1});
      check_dut(2, ov2, c2, rd2, alu2, wr2, en2, wd2, {1'b0, fwe2}, {5'b0, freg2}, occ2);
      check_dut(3, ov3, c3, rd3, alu3, wr3, en3, wd3, fwe3, freg3, occ3);
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_step();
      else model_reset();
      #1;
      check_all();
   endtask

   task automatic drive(input logic st, input logic fl, input logic iv, input logic [1:0] c,
                        input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] wr);
      stall_i  = st;
      flush_i  = fl;
      in_valid = iv;
      ctrl_in  = c;
      rd_in    = rd;
      alu_in   = alu;
      wr_in    = wr;
   endtask

   typedef struct {
      logic        st, fl, iv;
      logic [1:0]  c;
      logic [31:0] rd, alu;
      logic [4:0]  wr;
      logic        e_ov, e_en;
      logic [31:0] e_wd;
      logic        e_occ;
   } vec_t;

   vec_t tbl [7];

   initial begin
      tbl[0] = '{1'b0, 1'b0, 1'b1, 2'b01, 32'h0,    32'h1234, 5'd8, 1'b1, 1'b1, 32'h1234, 1'b1};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 2'b11, 32'hDEAD, 32'h0,    5'd0, 1'b1, 1'b0, 32'hDEAD, 1'b1};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 2'b01, 32'h0,    32'h5,    5'd3, 1'b0, 1'b0, 32'h5,    1'b0};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 2'b10, 32'hBEEF, 32'h7,    5'd9, 1'b1, 1'b0, 32'hBEEF, 1'b1};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 2'b01, 32'h0,    32'hAA,   5'd2, 1'b1, 1'b0, 32'hBEEF, 1'b1};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 2'b01, 32'h0,    32'hAA,   5'd2, 1'b1, 1'b1, 32'hAA,   1'b1};
      tbl[6] = '{1'b1, 1'b1, 1'b1, 2'b01, 32'h0,    32'h77,   5'd6, 1'b0, 1'b0,
                 CLR ? 32'h0 : 32'hAA, 1'b0};

      rst_n = 1'b0;
      drive(0, 0, 0, 2'b00, 32'h0, 32'h0, 5'd0);
      cycle();
      cycle();
      cmp("reset_occ3", 32'(occ3), 0);
      cmp("reset_wb_data3", wd3, 0);
      rst_n = 1'b1;

      // DEPTH=1 table
      for (int i = 0; i < 7; i++) begin
         drive(tbl[i].st, tbl[i].fl, tbl[i].iv, tbl[i].c, tbl[i].rd, tbl[i].alu, tbl[i].wr);
         cycle();
         cmp($sformatf("tbl%0d_out_valid", i), 32'(ov1), 32'(tbl[i].e_ov));
         cmp($sformatf("tbl%0d_wb_en", i), 32'(en1), 32'(tbl[i].e_en));
         cmp($sformatf("tbl%0d_wb_data", i), wd1, tbl[i].e_wd);
         cmp($sformatf("tbl%0d_occ", i), 32'(occ1), 32'(tbl[i].e_occ));
      end

      // DEPTH=3 ordering with a two-cycle stall: A at edge 3, B at 6, C at 7
      begin
         logic        exp_ov  [1:8];
         logic [31:0] exp_alu [1:8];
         drive(0, 1, 0, 2'b00, 32'h0, 32'h0, 5'd0);
         cycle();
         exp_ov  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
         exp_alu = '{32'h0, 32'h0, 32'hA1, 32'hA1, 32'hA1, 32'hB2, 32'hC3, 32'h0};
         for (int e = 1; e <= 8; e++) begin
            case (e)
               1: drive(0, 0, 1, 2'b01, 32'h0, 32'hA1, 5'd1);
               2: drive(0, 0, 1, 2'b01, 32'h0, 32'hB2, 5'd2);
               3: drive(0, 0, 1, 2'b01, 32'h0, 32'hC3, 5'd3);
               4, 5: drive(1, 0, 1, 2'b01, 32'h0, 32'h99, 5'd9);
               default: drive(0, 0, 0, 2'b00, 32'h0, 32'h0, 5'd0);
            endcase
            cycle();
            cmp($sformatf("order_e%0d_out_valid", e), 32'(ov3), 32'(exp_ov[e]));
            if (exp_ov[e]) cmp($sformatf("order_e%0d_alu", e), alu3, exp_alu[e]);
         end
      end

      // DEPTH=3 forwarding tap walk
      begin
         logic [2:0] exp_we [1:4];
         exp_we = '{3'b001, 3'b010, 3'b100, 3'b000};
         drive(0, 0, 1, 2'b01, 32'h0, 32'h44, 5'd4);
         for (int e = 1; e <= 4; e++) begin
            cycle();
            cmp($sformatf("fwd_e%0d_we", e), 32'(fwe3), 32'(exp_we[e]));
            if (e <= 3) cmp($sformatf("fwd_e%0d_reg", e), 32'(freg3[(e-1)*5 +: 5]), 32'd4);
            drive(0, 0, 0, 2'b00, 32'h0, 32'h0, 5'd7);
         end
      end

      // DEPTH=2 full chain, then flush together with stall
      drive(0, 0, 1, 2'b01, 32'h0, 32'h11, 5'd5);
      cycle();
      drive(0, 0, 1, 2'b01, 32'h0, 32'h22, 5'd6);
      cycle();
      cmp("full_occ2", 32'(occ2), 2);
      cmp("full_fwd_we2", 32'(fwe2), 32'b11);
      drive(1, 1, 1, 2'b01, 32'h0, 32'h33, 5'd7);
      cycle();
      cmp("flush_occ2", 32'(occ2), 0);
      cmp("flush_fwd_we2", 32'(fwe2), 0);
      cmp("flush_wb_en2", 32'(en2), 0);
      cmp("flush_alu2", alu2, CLR ? 32'h0 : 32'h11);

      // asynchronous reset between edges with occ=2
      drive(0, 0, 1, 2'b11, 32'h5A5A, 32'h1, 5'd3);
      cycle();
      cycle();
      cmp("prereset_occ2", 32'(occ2), 2);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      cmp("async_occ2", 32'(occ2), 0);
      cmp("async_wb_data2", wd2, 0);
      cmp("async_out_valid3", 32'(ov3), 0);
      #2 rst_n = 1'b1;

      // random traffic
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, 1'($urandom),
               2'($urandom), $urandom, $urandom, 5'($urandom_range(0, 7)));
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
